// File: rtl/sc_computer_pkg.sv
// Shared encodings for the single-cycle MIPS-subset computer: opcodes,
// function codes, ALU operation codes, next-PC selection and the decoded
// control word.
package sc_computer_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;

  // Link register used by jal
  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_LUI = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7,
    ALU_SRA = 4'd8
  } aluc_t;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'd0,
    PC_BRANCH = 2'd1,
    PC_JR     = 2'd2,
    PC_JUMP   = 2'd3
  } pc_sel_t;

  typedef struct packed {
    logic    wreg;    // write register file
    logic    wmem;    // write data RAM
    logic    m2reg;   // write-back from memory
    logic    jal;     // write pc+4 into r31
    logic    aluimm;  // ALU B operand is the immediate
    logic    sext;    // sign-extend the immediate
    logic    shift;   // ALU A operand is shamt
    logic    regrt;   // destination is rt instead of rd
    aluc_t   aluc;
    pc_sel_t pc_sel;
  } ctrl_t;

  function automatic logic [31:0] ext_imm16(input logic [15:0] imm, input logic sext);
    return {{16{sext & imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/sc_computer_if.sv
// Debug/observation bundle of the computer: PC, fetched instruction, ALU
// result, data RAM read word and the two memory phase strobes.
interface sc_computer_if;
  import sc_computer_pkg::*;

  logic [31:0] pc;
  logic [31:0] inst;
  logic [31:0] aluout;
  logic [31:0] memout;
  logic        imem_clk;
  logic        dmem_clk;

  modport master (output pc, inst, aluout, memout, imem_clk, dmem_clk);
  modport slave  (input  pc, inst, aluout, memout, imem_clk, dmem_clk);
endinterface

// File: rtl/sc_computer_cpu.sv
// Single-cycle CPU core: decoder, register file, ALU and next-PC logic.
// Memories live outside; instruction and read data arrive combinationally.
module sc_cpu
  import sc_computer_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] inst,
  input  logic [31:0] memout,
  output logic [31:0] pc,
  output logic [31:0] aluout,
  output logic [31:0] store_data,
  output logic        wmem
);

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt, dest;
  logic [31:0] regs [32];
  logic [31:0] qa, qb, imm_ext, alu_a, alu_b, wb_data;
  logic signed [31:0] alu_b_s;
  logic [31:0] pc_plus4, br_target, jmp_target, pc_next;
  ctrl_t       ctl;

  assign op    = inst[31:26];
  assign rs    = inst[25:21];
  assign rt    = inst[20:16];
  assign rd    = inst[15:11];
  assign shamt = inst[10:6];
  assign funct = inst[5:0];

  // r0 is hard-wired to zero on the read side
  assign qa = (rs == 5'd0) ? 32'd0 : regs[rs];
  assign qb = (rt == 5'd0) ? 32'd0 : regs[rt];

  // Decode opcode/funct into the control word; branches resolve here
  always_comb begin
    ctl        = '0;
    ctl.aluc   = ALU_ADD;
    ctl.pc_sel = PC_SEQ;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin ctl.wreg = 1'b1; ctl.aluc = ALU_ADD; end
          FN_SUB: begin ctl.wreg = 1'b1; ctl.aluc = ALU_SUB; end
          FN_AND: begin ctl.wreg = 1'b1; ctl.aluc = ALU_AND; end
          FN_OR:  begin ctl.wreg = 1'b1; ctl.aluc = ALU_OR;  end
          FN_XOR: begin ctl.wreg = 1'b1; ctl.aluc = ALU_XOR; end
          FN_SLL: begin ctl.wreg = 1'b1; ctl.shift = 1'b1; ctl.aluc = ALU_SLL; end
          FN_SRL: begin ctl.wreg = 1'b1; ctl.shift = 1'b1; ctl.aluc = ALU_SRL; end
          FN_SRA: begin ctl.wreg = 1'b1; ctl.shift = 1'b1; ctl.aluc = ALU_SRA; end
          FN_JR:  ctl.pc_sel = PC_JR;
          default: ;
        endcase
      end
      OP_ADDI: begin ctl.wreg = 1'b1; ctl.aluimm = 1'b1; ctl.sext = 1'b1; ctl.regrt = 1'b1; end
      OP_ANDI: begin ctl.wreg = 1'b1; ctl.aluimm = 1'b1; ctl.regrt = 1'b1; ctl.aluc = ALU_AND; end
      OP_ORI:  begin ctl.wreg = 1'b1; ctl.aluimm = 1'b1; ctl.regrt = 1'b1; ctl.aluc = ALU_OR;  end
      OP_XORI: begin ctl.wreg = 1'b1; ctl.aluimm = 1'b1; ctl.regrt = 1'b1; ctl.aluc = ALU_XOR; end
      OP_LUI:  begin ctl.wreg = 1'b1; ctl.aluimm = 1'b1; ctl.regrt = 1'b1; ctl.aluc = ALU_LUI; end
      OP_LW: begin
        ctl.wreg = 1'b1; ctl.m2reg = 1'b1; ctl.aluimm = 1'b1; ctl.sext = 1'b1; ctl.regrt = 1'b1;
      end
      OP_SW:  begin ctl.wmem = 1'b1; ctl.aluimm = 1'b1; ctl.sext = 1'b1; end
      OP_BEQ: begin
        ctl.sext = 1'b1; ctl.aluc = ALU_SUB;
        ctl.pc_sel = (qa == qb) ? PC_BRANCH : PC_SEQ;
      end
      OP_BNE: begin
        ctl.sext = 1'b1; ctl.aluc = ALU_SUB;
        ctl.pc_sel = (qa != qb) ? PC_BRANCH : PC_SEQ;
      end
      OP_J:   ctl.pc_sel = PC_JUMP;
      OP_JAL: begin ctl.pc_sel = PC_JUMP; ctl.wreg = 1'b1; ctl.jal = 1'b1; end
      default: ;
    endcase
  end

  assign imm_ext = ext_imm16(inst[15:0], ctl.sext);
  assign alu_a   = ctl.shift ? {27'd0, shamt} : qa;
  assign alu_b   = ctl.aluimm ? imm_ext : qb;
  assign alu_b_s = alu_b;

  // ALU; shifts take the amount from A and shift B (rt)
  always_comb begin
    aluout = '0;
    case (ctl.aluc)
      ALU_ADD: aluout = alu_a + alu_b;
      ALU_SUB: aluout = alu_a - alu_b;
      ALU_AND: aluout = alu_a & alu_b;
      ALU_OR:  aluout = alu_a | alu_b;
      ALU_XOR: aluout = alu_a ^ alu_b;
      ALU_LUI: aluout = {alu_b[15:0], 16'd0};
      ALU_SLL: aluout = alu_b << alu_a[4:0];
      ALU_SRL: aluout = alu_b >> alu_a[4:0];
      ALU_SRA: aluout = alu_b_s >>> alu_a[4:0];
      default: aluout = '0;
    endcase
  end

  assign wb_data    = ctl.jal ? pc_plus4 : (ctl.m2reg ? memout : aluout);
  assign dest       = ctl.jal ? REG_RA : (ctl.regrt ? rt : rd);
  assign store_data = qb;
  assign wmem       = ctl.wmem;

  // Register file: cleared by reset, writes to r0 dropped
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (ctl.wreg && (dest != 5'd0)) begin
      regs[dest] <= wb_data;
    end
  end

  assign pc_plus4   = pc + 32'd4;
  assign br_target  = pc_plus4 + {imm_ext[29:0], 2'b00};
  assign jmp_target = {pc_plus4[31:28], inst[25:0], 2'b00};

  // Next-PC selection
  always_comb begin
    pc_next = pc_plus4;
    case (ctl.pc_sel)
      PC_BRANCH: pc_next = br_target;
      PC_JR:     pc_next = qa;
      PC_JUMP:   pc_next = jmp_target;
      default:   pc_next = pc_plus4;
    endcase
  end

  // Program counter
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) pc <= '0;
    else         pc <= pc_next;
  end

endmodule

// File: rtl/sc_computer.sv
// Lab computer top: single-cycle CPU, instruction ROM (contents supplied as
// a packed parameter, word i at bits [32*i +: 32]) and data RAM.
module sc_computer
  import sc_computer_pkg::*;
#(
  parameter int IMEM_DEPTH = 64,
  parameter int DMEM_DEPTH = 32,
  parameter logic [IMEM_DEPTH*32-1:0] IMEM_INIT = '0
) (
  input  logic          resetn,
  input  logic          clock,
  input  logic          mem_clk,
  sc_computer_if.master dbg
);

  localparam int IW = $clog2(IMEM_DEPTH);
  localparam int DW = $clog2(DMEM_DEPTH);

  logic [31:0]   pc, inst, aluout, memout, store_data;
  logic          wmem;
  logic [IW-1:0] iaddr;
  logic [DW-1:0] daddr;
  logic [31:0]   dmem [DMEM_DEPTH];
  logic          unused_addr_bits;

  sc_cpu cpu (
    .clock      (clock),
    .resetn     (resetn),
    .inst       (inst),
    .memout     (memout),
    .pc         (pc),
    .aluout     (aluout),
    .store_data (store_data),
    .wmem       (wmem)
  );

  // PC beyond the ROM wraps by dropping the upper address bits
  assign iaddr  = pc[IW+1:2];
  assign inst   = IMEM_INIT[int'(iaddr)*32 +: 32];
  assign daddr  = aluout[DW+1:2];
  assign memout = dmem[daddr];

  assign unused_addr_bits = ^{pc[31:IW+2], pc[1:0], aluout[31:DW+2], aluout[1:0]};

  // Data RAM write port; contents survive reset
  always_ff @(posedge clock) begin
    if (wmem) dmem[daddr] <= store_data;
  end

  assign dbg.pc       = pc;
  assign dbg.inst     = inst;
  assign dbg.aluout   = aluout;
  assign dbg.memout   = memout;
  assign dbg.imem_clk = mem_clk & clock;
  assign dbg.dmem_clk = mem_clk & ~clock;

endmodule

// File: tb/tb_sc_computer.sv
// Directed bench for sc_computer: runs a hand-assembled program and checks
// the PC trace, fetched words, ALU results, load data, strobes and reset.
`timescale 1ns/1ps
module tb_sc_computer;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sh,
                                        input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sh, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] a);
    return {op, a};
  endfunction

  function automatic logic [64*32-1:0] build_prog();
    logic [64*32-1:0] p;
    p = '0;
    p[32*0  +: 32] = enc_i(6'h08, 5'd0, 5'd1, 16'd5);          // addi r1,r0,5
    p[32*1  +: 32] = enc_i(6'h08, 5'd0, 5'd2, 16'hFFFD);       // addi r2,r0,-3
    p[32*2  +: 32] = enc_r(5'd1, 5'd2, 5'd3, 5'd0, 6'h20);     // add r3,r1,r2
    p[32*3  +: 32] = enc_r(5'd1, 5'd2, 5'd4, 5'd0, 6'h22);     // sub r4,r1,r2
    p[32*4  +: 32] = enc_i(6'h04, 5'd1, 5'd1, 16'd2);          // 0x10 beq r1,r1,+2
    p[32*5  +: 32] = enc_i(6'h08, 5'd0, 5'd10, 16'd1);         // skipped
    p[32*6  +: 32] = enc_i(6'h08, 5'd0, 5'd10, 16'd2);         // skipped
    p[32*7  +: 32] = enc_i(6'h05, 5'd1, 5'd1, 16'd2);          // 0x1C bne r1,r1,+2
    p[32*8  +: 32] = enc_j(6'h03, 26'h10);                     // 0x20 jal 0x40
    p[32*9  +: 32] = enc_r(5'd0, 5'd1, 5'd5, 5'd4, 6'h00);     // 0x24 sll r5,r1,4
    p[32*10 +: 32] = enc_i(6'h0F, 5'd0, 5'd6, 16'h1234);       // lui r6,0x1234
    p[32*11 +: 32] = enc_i(6'h0D, 5'd6, 5'd6, 16'h5678);       // ori r6,r6,0x5678
    p[32*12 +: 32] = enc_i(6'h2B, 5'd0, 5'd6, 16'd8);          // sw r6,8(r0)
    p[32*13 +: 32] = enc_i(6'h23, 5'd0, 5'd7, 16'd8);          // lw r7,8(r0)
    p[32*14 +: 32] = enc_r(5'd7, 5'd0, 5'd8, 5'd0, 6'h20);     // add r8,r7,r0
    p[32*15 +: 32] = enc_j(6'h02, 26'h11);                     // j 0x44
    p[32*16 +: 32] = enc_r(5'd31, 5'd0, 5'd0, 5'd0, 6'h08);    // 0x40 jr r31
    p[32*17 +: 32] = enc_i(6'h08, 5'd0, 5'd0, 16'd7);          // 0x44 addi r0,r0,7
    p[32*18 +: 32] = enc_r(5'd0, 5'd0, 5'd9, 5'd0, 6'h20);     // add r9,r0,r0
    p[32*19 +: 32] = enc_r(5'd0, 5'd2, 5'd10, 5'd1, 6'h03);    // sra r10,r2,1
    p[32*20 +: 32] = enc_r(5'd0, 5'd2, 5'd11, 5'd28, 6'h02);   // srl r11,r2,28
    p[32*21 +: 32] = enc_i(6'h0C, 5'd2, 5'd12, 16'hFFFF);      // andi r12,r2,0xFFFF
    p[32*22 +: 32] = enc_r(5'd1, 5'd2, 5'd13, 5'd0, 6'h26);    // xor r13,r1,r2
    p[32*23 +: 32] = enc_i(6'h05, 5'd1, 5'd2, 16'd1);          // 0x5C bne r1,r2,+1
    p[32*24 +: 32] = enc_i(6'h08, 5'd0, 5'd14, 16'd99);        // skipped
    p[32*25 +: 32] = enc_r(5'd14, 5'd0, 5'd15, 5'd0, 6'h20);   // add r15,r14,r0
    p[32*26 +: 32] = enc_i(6'h0E, 5'd1, 5'd16, 16'hFFFF);      // xori r16,r1,0xFFFF
    p[32*27 +: 32] = enc_r(5'd1, 5'd2, 5'd17, 5'd0, 6'h25);    // or r17,r1,r2
    p[32*28 +: 32] = enc_r(5'd1, 5'd2, 5'd18, 5'd0, 6'h24);    // and r18,r1,r2
    p[32*29 +: 32] = enc_i(6'h3F, 5'd0, 5'd1, 16'h0077);       // undefined opcode
    p[32*30 +: 32] = enc_r(5'd1, 5'd0, 5'd19, 5'd0, 6'h20);    // add r19,r1,r0
    p[32*31 +: 32] = enc_j(6'h02, 26'h1F);                     // 0x7C j 0x7C
    return p;
  endfunction

  localparam logic [64*32-1:0] PROG = build_prog();

  logic resetn, clock, mem_clk;
  int   n_checks = 0;
  int   n_errors = 0;

  sc_computer_if bus ();

  sc_computer #(.IMEM_DEPTH(64), .DMEM_DEPTH(32), .IMEM_INIT(PROG)) dut (
    .resetn  (resetn),
    .clock   (clock),
    .mem_clk (mem_clk),
    .dbg     (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    mem_clk = 1'b0;
    forever #2.5 mem_clk = ~mem_clk;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] prog_word(input logic [31:0] a);
    return PROG[int'(a[7:2])*32 +: 32];
  endfunction

  // Expected execution trace, one entry per clock
  logic [31:0] exp_pc [30] = '{
    32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h1C, 32'h20, 32'h40, 32'h24, 32'h28,
    32'h2C, 32'h30, 32'h34, 32'h38, 32'h3C, 32'h44, 32'h48, 32'h4C, 32'h50, 32'h54,
    32'h58, 32'h5C, 32'h64, 32'h68, 32'h6C, 32'h70, 32'h74, 32'h78, 32'h7C, 32'h7C};
  logic [31:0] exp_alu [30] = '{
    32'h5, 32'hFFFFFFFD, 32'h2, 32'h8, 32'h0, 32'h0, 32'h0, 32'h0, 32'h50, 32'h12340000,
    32'h12345678, 32'h8, 32'h8, 32'h12345678, 32'h0, 32'h7, 32'h0, 32'hFFFFFFFE, 32'hF,
    32'h0000FFFD, 32'hFFFFFFF8, 32'h0, 32'h0, 32'h0000FFFA, 32'hFFFFFFFD, 32'h5, 32'h0,
    32'h5, 32'h0, 32'h0};
  logic [0:29] use_alu = 30'b1111_0000_1111_1101_1111_1011_1101_00;

  initial begin
    resetn = 1'b0;
    // reset held across a rising edge
    @(negedge clock);
    check_val("rst_pc", bus.pc, 32'h0);
    check_val("rst_inst", bus.inst, prog_word(32'h0));
    check_val("rst_alu", bus.aluout, 32'h5);
    #2 resetn = 1'b1;
    #1;

    for (int k = 0; k < 30; k++) begin
      if (k > 0) begin
        @(posedge clock);
        #2;
      end
      check_val($sformatf("pc[%0d]", k), bus.pc, exp_pc[k]);
      check_val($sformatf("inst[%0d]", k), bus.inst, prog_word(exp_pc[k]));
      if (use_alu[k])
        check_val($sformatf("alu[%0d]", k), bus.aluout, exp_alu[k]);
      if (k == 12)
        check_val("memout_lw", bus.memout, 32'h12345678);
    end

    // phase strobes across one clock period
    @(posedge clock);
    #1.25;
    check_val("imem_clk_h0", {31'd0, bus.imem_clk}, 32'd0);
    check_val("dmem_clk_h0", {31'd0, bus.dmem_clk}, 32'd0);
    #2.5;
    check_val("imem_clk_h1", {31'd0, bus.imem_clk}, 32'd1);
    check_val("dmem_clk_h1", {31'd0, bus.dmem_clk}, 32'd0);
    #2.5;
    check_val("imem_clk_l0", {31'd0, bus.imem_clk}, 32'd0);
    check_val("dmem_clk_l0", {31'd0, bus.dmem_clk}, 32'd0);
    #2.5;
    check_val("imem_clk_l1", {31'd0, bus.imem_clk}, 32'd0);
    check_val("dmem_clk_l1", {31'd0, bus.dmem_clk}, 32'd1);

    // asynchronous reset away from any clock edge
    check_val("pre_arst_pc", bus.pc, 32'h7C);
    resetn = 1'b0;
    #0.5;
    check_val("arst_pc", bus.pc, 32'h0);
    check_val("arst_inst", bus.inst, prog_word(32'h0));
    @(posedge clock);
    #1;
    check_val("arst_hold_pc", bus.pc, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
